// File: rtl/i2c_master_tx.sv
// Single-byte I2C write master: START, 7-bit address + W, ACK, data byte, ACK, STOP.
// Every bus phase is a 4-quarter slot; each quarter lasts CLK_DIV clk cycles.
// scl and the sda pull-down enable are registered so the bus pins never glitch.
module i2c_master_tx #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [15:0] div_cnt, div_n;
  logic [1:0]  quarter, quarter_n;
  logic [3:0]  bit_cnt, bit_n;
  logic        nack_r, nack_n;
  logic        done_n, ack_err_n;
  logic        scl_n, sda_oe, sda_oe_n;
  logic [6:0]  addr_r;
  logic [7:0]  data_r;
  logic [7:0]  addr_byte;
  logic        bit_val;
  logic        accept, qtick, slot_end;

  // Bus levels for one quarter of a slot, returned as {scl, sda_pull_low}.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                           input logic b);
    case (st)
      START:              bus_drive = {q != 2'd3, q != 2'd0};
      ADDR, DATA:         bus_drive = {q == 2'd1 || q == 2'd2, ~b};
      ADDR_ACK, DATA_ACK: bus_drive = {q == 2'd1 || q == 2'd2, 1'b0};
      STOP:               bus_drive = {q != 2'd0, ~q[1]};
      default:            bus_drive = 2'b10;
    endcase
  endfunction

  // busy covers the whole frame plus the done cycle.
  assign busy      = (state != IDLE) || done;
  assign accept    = start && !busy;
  assign qtick     = (div_cnt == DIV_LAST);
  assign slot_end  = qtick && (quarter == 2'd3);
  assign addr_byte = {addr_r, 1'b0};
  assign sda       = sda_oe ? 1'b0 : 1'bz;

  // Next-state, counter and registered-pin decode.
  always_comb begin
    state_n   = state;
    div_n     = div_cnt;
    quarter_n = quarter;
    bit_n     = bit_cnt;
    nack_n    = nack_r;
    done_n    = 1'b0;
    ack_err_n = ack_err;
    if (state == IDLE) begin
      div_n     = 16'd0;
      quarter_n = 2'd0;
      if (accept) begin
        state_n   = START;
        ack_err_n = 1'b0;
        nack_n    = 1'b0;
      end
    end else begin
      if (qtick) begin
        div_n     = 16'd0;
        quarter_n = quarter + 2'd1;
      end else begin
        div_n = div_cnt + 16'd1;
      end
      // Slave response is sampled once, at the first cycle of q2 (scl high).
      if ((state == ADDR_ACK || state == DATA_ACK) && quarter == 2'd2 && div_cnt == 16'd0)
        nack_n = sda;
      if (slot_end) begin
        case (state)
          START: begin
            state_n = ADDR;
            bit_n   = 4'd7;
          end
          ADDR: begin
            if (bit_cnt == 4'd0) state_n = ADDR_ACK;
            else                 bit_n   = bit_cnt - 4'd1;
          end
          ADDR_ACK: begin
            if (nack_r) begin
              ack_err_n = 1'b1;
              state_n   = STOP;
            end else begin
              state_n = DATA;
              bit_n   = 4'd7;
            end
          end
          DATA: begin
            if (bit_cnt == 4'd0) state_n = DATA_ACK;
            else                 bit_n   = bit_cnt - 4'd1;
          end
          DATA_ACK: begin
            ack_err_n = nack_r;
            state_n   = STOP;
          end
          STOP: begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
    // Bit value only changes at slot boundaries, so sda only moves in q0.
    bit_val = (state_n == ADDR) ? addr_byte[bit_n[2:0]] : data_r[bit_n[2:0]];
    {scl_n, sda_oe_n} = bus_drive(state_n, quarter_n, bit_val);
  end

  // Control state, counters and bus pins; reset aborts without a STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= 16'd0;
      quarter <= 2'd0;
      bit_cnt <= 4'd0;
      nack_r  <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      quarter <= quarter_n;
      bit_cnt <= bit_n;
      nack_r  <= nack_n;
      done    <= done_n;
      ack_err <= ack_err_n;
      scl     <= scl_n;
      sda_oe  <= sda_oe_n;
    end
  end

  // Address and data captured on the accept cycle only.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_r <= addr;
      data_r <= data;
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: behavioural I2C slave plus a bus decoder that turns
// the pins into START / bit / STOP events, compared against frames built from
// the I2C write-transaction rules.
module tb_i2c_master_tx;

  localparam int CD = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h42;
  localparam int EV_START = 2;
  localparam int EV_STOP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] data = 8'd0;
  logic       busy, done, ack_err, scl;
  wire        sda_w;

  logic slave_drive = 1'b0;
  logic slave_ack_data = 1'b1;
  logic addr_match = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  int   rise_cnt = 0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;
  int   ev_q[$];
  int   busy_cnt = 0;
  int   done_cnt = 0;
  int   last_busy_len = 0;
  int   last_ack_err = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  assign sda_w = slave_drive ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_master_tx #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data(data),
    .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Bus decoder, slave responder and busy/done bookkeeping, sampled on negedge.
  always @(negedge clk) begin
    if (scl && prev_scl && (sda_w != prev_sda)) begin
      if (!sda_w) begin
        ev_q.push_back(EV_START);
        rise_cnt = 0;
        rx_byte  = 8'd0;
      end else begin
        // The clock pulse inside a STOP is not a data bit.
        if (ev_q.size() > 0 && ev_q[$] < EV_START) void'(ev_q.pop_back());
        ev_q.push_back(EV_STOP);
      end
    end else if (scl && !prev_scl) begin
      ev_q.push_back(int'(sda_w));
      rise_cnt++;
      if (rise_cnt <= 8) rx_byte = {rx_byte[6:0], sda_w};
    end else if (!scl && prev_scl) begin
      if (rise_cnt == 8) begin
        addr_match  = (rx_byte == {SLAVE_ADDR, 1'b0});
        slave_drive = addr_match;
      end else if (rise_cnt == 9 || rise_cnt == 18) begin
        slave_drive = 1'b0;
      end else if (rise_cnt == 17) begin
        slave_drive = addr_match && slave_ack_data;
      end
    end
    if (busy) busy_cnt++;
    else      busy_cnt = 0;
    if (done) begin
      done_cnt++;
      last_busy_len = busy_cnt;
      last_ack_err  = int'(ack_err);
    end
    prev_scl = scl;
    prev_sda = sda_w;
  end

  // One write transaction; optionally pokes start mid-address with other values.
  task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic ack_d,
                         input logic poke);
    int   exp_q[$];
    int   c;
    int   d0;
    logic addr_ok;
    logic [7:0] ab;
    @(negedge clk); #1;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_scl", int'(scl), 1);
    check("idle_sda", int'(sda_w), 1);
    ev_q.delete();
    slave_ack_data = ack_d;
    d0 = done_cnt;
    start = 1'b1; addr = a; data = d;
    @(negedge clk); #1;
    start = 1'b0; addr = 7'($urandom); data = 8'($urandom);
    check("busy_rise", int'(busy), 1);
    c = 0;
    while (done_cnt == d0 && c < 200 * CD) begin
      if (poke && c == 20 * CD) begin
        start = 1'b1; addr = ~a; data = ~d;
      end else begin
        start = 1'b0;
      end
      @(negedge clk); #1;
      c++;
    end
    start = 1'b0;
    check("done_seen", done_cnt - d0, 1);
    addr_ok = (a == SLAVE_ADDR);
    check("busy_cycles", last_busy_len, (addr_ok ? 80 : 44) * CD + 1);
    check("ack_err", last_ack_err, int'(!(addr_ok && ack_d)));
    exp_q.push_back(EV_START);
    ab = {a, 1'b0};
    for (int i = 7; i >= 0; i--) exp_q.push_back(int'(ab[i]));
    exp_q.push_back(int'(!addr_ok));
    if (addr_ok) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(int'(d[i]));
      exp_q.push_back(int'(!ack_d));
    end
    exp_q.push_back(EV_STOP);
    check("frame_len", ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < ev_q.size()) check($sformatf("frame_ev%0d", i), ev_q[i], exp_q[i]);
  endtask

  initial begin
    int d0;
    int stops;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ack_err", int'(ack_err), 0);
    check("rst_scl", int'(scl), 1);
    check("rst_sda", int'(sda_w), 1);
    // Reset wins over a simultaneous start.
    start = 1'b1; addr = SLAVE_ADDR; data = 8'h11;
    @(negedge clk); #1;
    check("rst_prio_busy", int'(busy), 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk); #1;
    check("rst_prio_busy2", int'(busy), 0);

    run_txn(SLAVE_ADDR, 8'hA5, 1'b1, 1'b0);
    run_txn(7'h13, 8'h5C, 1'b1, 1'b0);
    run_txn(SLAVE_ADDR, 8'h6E, 1'b0, 1'b0);
    run_txn(SLAVE_ADDR, 8'hC3, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++)
      run_txn(($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom),
              8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset during the slot carrying data[3] (second cycle of its q0).
    @(negedge clk); #1;
    ev_q.delete();
    slave_ack_data = 1'b1;
    d0 = done_cnt;
    start = 1'b1; addr = SLAVE_ADDR; data = 8'h3C;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (56 * CD + 1) @(negedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    check("abort_scl_before", int'(scl), 0);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_scl", int'(scl), 1);
    check("abort_sda", int'(sda_w), 1);
    check("abort_ack_err", int'(ack_err), 0);
    repeat (400) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    stops = 0;
    foreach (ev_q[i]) if (ev_q[i] == EV_STOP) stops++;
    check("abort_no_stop", stops, 0);

    run_txn(SLAVE_ADDR, 8'h81, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_tx.md
I2C_MASTER_TX -- requirements
Module: i2c_master_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250; clk cycles per SCL quarter-period (legal range 2..65535). The SCL period is 4*CLK_DIV, which gives 100 kHz at 100 MHz.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a single-byte write; sampled only when busy=0.
REQ-005 SHALL have port addr  input  7  target slave address.
REQ-006 SHALL have port data  input  8  byte to write.
REQ-007 SHALL have port busy  output  1  high from start acceptance until the cycle after done.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the transaction ends.
REQ-009 SHALL have port ack_err  output  1  NACK seen in the last transaction; valid with done, held until the next accept.
REQ-010 SHALL have port scl  output  1  I2C clock, push-pull, no clock stretching.
REQ-011 SHALL have port sda  inout  1  I2C data, open-drain: driven 0 or released (Z) only, never driven 1.

Function
REQ-012 SHALL latch addr and data on the accept cycle (start=1, busy=0); busy SHALL rise the following cycle.
REQ-013 SHALL ignore start while busy=1.
REQ-014 SHALL sequence the FSM IDLE->START->ADDR->ADDR_ACK->DATA->DATA_ACK->STOP->IDLE; a NACK in ADDR_ACK SHALL go ADDR_ACK->STOP, skipping DATA.
REQ-015 SHALL advance one quarter-phase q0..q3 every CLK_DIV cycles via a quarter-cycle counter; every state except IDLE SHALL be built from 4-quarter bit slots.
REQ-016 SHALL drive the START slot as follows: q0 scl=1 sda=Z; q1 scl=1 sda=0; q2 scl=1 sda=0; q3 scl=0 sda=0.
REQ-017 SHALL drive each data/address bit slot as follows: q0 scl=0 sda=bit; q1 scl=1; q2 scl=1; q3 scl=0. sda SHALL change only in q0.
REQ-018 SHALL send ADDR as 8 bits, MSB first: addr[6:0] then R/W=0.
REQ-019 SHALL release sda in ADDR_ACK and DATA_ACK, sample sda on the first cycle of q2, and treat 0 as ACK and 1 as NACK.
REQ-020 SHALL send DATA as data[7:0], MSB first.
REQ-021 SHALL drive the STOP slot as follows: q0 scl=0 sda=0; q1 scl=1 sda=0; q2 scl=1 sda=Z; q3 scl=1 sda=Z.
REQ-022 SHALL make the ACK transaction 20 slots (80*CLK_DIV cycles) from busy rise to STOP end, with done on the next cycle.
REQ-023 SHALL make the NACK transaction 11 slots (44*CLK_DIV cycles), with done asserted and ack_err=1.
REQ-024 SHALL set ack_err=1 on a NACK in DATA_ACK while still completing STOP.
REQ-025 SHALL lower busy in the cycle after done; start may be accepted in that same cycle.
REQ-026 SHALL keep scl=1 and sda=Z whenever in IDLE.
REQ-027 SHALL use a bit counter of 4 bits (7 down to 0) and a quarter counter of 16 bits, with no wrap beyond its terminal value.

Reset
REQ-028 SHALL on rst=1 set state=IDLE, scl=1, sda=Z, busy=0, done=0, ack_err=0, and clear the counters on the next clk edge.
REQ-029 SHALL let rst mid-transaction abort immediately with no STOP generated and no done pulse; the bus returns to scl=1, sda=Z.
REQ-030 SHALL give rst priority over a simultaneous start.

Verification
REQ-031 SHALL verify ACK write with CLK_DIV=4, bench slave at 7'h42 ACKing, start with addr=7'h42 data=8'hA5: the bus shows START, 0x84, ACK, 0xA5, ACK, STOP; done pulses 321 cycles after busy rises; ack_err=0.
REQ-032 SHALL verify address NACK with addr=7'h13 and the slave silent: the bus shows START, 0x26, NACK, STOP with no data bits; done after 177 cycles; ack_err=1.
REQ-033 SHALL verify data NACK with the slave ACKing the address and NACKing the data: the full 20-slot frame including STOP is sent; ack_err=1.
REQ-034 SHALL verify start pulsed at mid-ADDR with different addr/data: it is ignored and the transmitted bytes are unchanged.
REQ-035 SHALL verify rst asserted during the DATA bit 3 slot: the next cycle shows scl=1, sda=Z, busy=0, and no done pulse occurs.
REQ-036 SHALL verify a bus protocol checker on every run: sda never transitions while scl=1 except at START q1 and STOP q2, and sda is never driven 1.
